// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: d = (a - b - bin) mod 2^W, one bit per clock, LSB first.
//   A single full-subtractor cell and a borrow flop replace a W-bit ripple chain.
//   Latency is W cycles from request accept to out_valid. Throughput is one
//   operation every W+2 cycles when out_ready is held high.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to add the ovf output, which
//   flags signed two's-complement overflow of a - b - bin.
//
// Parameters
//   W          operand/result width, W >= 2
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid (a, b, bin)
//   in_ready   request ready, high only while idle
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  response valid (d, bout, ovf)
//   out_ready  response accepted by consumer
//   d          difference
//   bout       borrow out, 1 iff a < b + bin (unsigned)
//   ovf        signed overflow (SERIAL_SUB_OVF_EN only)
//
// State | meaning
//   IDLE | waiting for a request, in_ready high
//   RUN  | one difference bit per clock, cnt = bit index
//   DONE | result held on d/bout/ovf until out_ready
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          brw;
  logic [CW-1:0] cnt;
  logic          dbit;
  logic          brw_nxt;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign dbit    = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_nxt = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Difference bits fill the MSB slots that the minuend vacates, so
          // after W shifts a_sh holds the whole result.
          a_sh <= {dbit, a_sh[W-1:1]};
          b_sh <= {1'b0, b_sh[W-1:1]};
          brw  <= brw_nxt;
          if (cnt == CNT_LAST) begin
            d     <= {dbit, a_sh[W-1:1]};
            bout  <= brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB differs from borrow out of it exactly on
            // signed overflow.
            ovf   <= brw ^ brw_nxt;
`endif
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (W=8). A latency/arithmetic reference model
// predicts in_ready, out_valid and the result every cycle; directed operations
// additionally pin the model and the DUT to hand-computed values.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic with plain integers.
  function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] r, output logic bo, output logic ov);
    int ux, uy, ci, full, sx, sy, s;
    ux = int'(x);
    uy = int'(y);
    ci = c ? 1 : 0;
    full = ux - uy - ci;
    bo = (full < 0);
    r = full[W-1:0];
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    s = sx - sy - ci;
    ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endfunction

  // Cycle model: at each negedge, compare the DUT to the prediction, then
  // advance the prediction across the coming rising edge.
  bit           m_on = 1'b0;
  logic         m_in_ready, m_out_valid;
  int           m_wait;
  logic [W-1:0] m_d, p_d;
  logic         m_bout, p_bout, m_ovf, p_ovf;

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_in_ready", in_ready, m_in_ready);
      chk("model_out_valid", out_valid, m_out_valid);
      if (m_out_valid) begin
        chk("model_d", d, m_d);
        chk("model_bout", bout, m_bout);
`ifdef SERIAL_SUB_OVF_EN
        chk("model_ovf", ovf, m_ovf);
`endif
      end
    end
    if (rst) begin
      m_on = 1'b1;
      m_in_ready = 1'b1;
      m_out_valid = 1'b0;
      m_wait = 0;
    end else if (m_on) begin
      if (m_in_ready && in_valid) begin
        ref_sub(a, b, bin, p_d, p_bout, p_ovf);
        m_in_ready = 1'b0;
        m_wait = W;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_out_valid = 1'b1;
          m_d = p_d;
          m_bout = p_bout;
          m_ovf = p_ovf;
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 1'b0;
        m_in_ready = 1'b1;
      end
    end
  end

  // Caller is at posedge+1. Returns at posedge+1 just after the accept edge.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                      input bit keep_valid, output int t_acc);
    bit got = 1'b0;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    chk("accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    t_acc = cyc;
    if (!keep_valid) begin
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic wait_valid(input string tag, input int t_acc, input bit lit,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk({tag, "_valid_timeout"}, seen, 1'b1);
    chk({tag, "_latency"}, cyc - t_acc, W);
    if (lit) begin
      chk({tag, "_d"}, d, ed);
      chk({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, ovf, eo);
`else
      if (eo === 1'bx) chk({tag, "_ovf_arg"}, eo, 1'b0);
`endif
    end
  endtask

  task automatic pin_model(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    logic [W-1:0] md;
    logic mb, mo;
    ref_sub(xa, xb, xbin, md, mb, mo);
    chk({tag, "_ref_d"}, md, ed);
    chk({tag, "_ref_bout"}, mb, eb);
    chk({tag, "_ref_ovf"}, mo, eo);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int t;
    pin_model(tag, xa, xb, xbin, ed, eb, eo);
    send(xa, xb, xbin, 1'b0, t);
    wait_valid(tag, t, 1'b1, ed, eb, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int t1, t2, tr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_d", d, 8'h00);
    chk("reset_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", ovf, 1'b0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("t1",    8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    run_op("t2",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t3a",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t3b",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("aeqb",  8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("wrap",  8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);

    // Back-to-back with in_valid held high across the first operation.
    pin_model("t4a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    pin_model("t4b", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h10, 8'h0F, 1'b1, 1'b1, t1);
    a = 8'hFF; b = 8'h00; bin = 1'b1;
    wait_valid("t4a", t1, 1'b1, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    send(8'hFF, 8'h00, 1'b1, 1'b0, t2);
    chk("t4_spacing", t2 - t1, W + 2);
    wait_valid("t4b", t2, 1'b1, 8'hFE, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Consumer stall: result must hold for 5 cycles.
    pin_model("t5", 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(8'hC3, 8'h3C, 1'b0, 1'b0, t1);
    wait_valid("t5", t1, 1'b1, 8'h87, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_hold_d", d, 8'h87);
      chk("t5_hold_bout", bout, 1'b0);
      chk("t5_hold_valid", out_valid, 1'b1);
      chk("t5_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_before_hs", out_valid, 1'b1);
    @(negedge clk);
    chk("t5_valid_after_hs", out_valid, 1'b0);
    chk("t5_in_ready_after_hs", in_ready, 1'b1);
    @(posedge clk); #1;

    // Reset sampled while bit 4 is being processed.
    send(8'h00, 8'hFF, 1'b1, 1'b0, tr);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    run_op("t6", 8'h02, 8'h03, 1'b0, 8'hFF, 1'b1, 1'b0);

    // A few further operands checked by the cycle model only.
    for (int i = 0; i < 6; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, t1);
      wait_valid("rnd", t1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
